// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin CPU/host data-memory arbiter with capped host burst lock and MMIO result register
module dmem_port_arbiter #(
    parameter logic [31:0] MMIO_ADDR = 32'h02000000,
    parameter int unsigned LOCK_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        host_req,
    input  logic        host_lock,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  result,
    output logic        result_valid
);
    localparam logic [7:0] LMAX = 8'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, CPU_OWN, HOST_OWN, HOST_LOCKED} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_ptr_host, w_ptr_nxt;
    logic [7:0]  r_lock_cnt, w_lock_cnt_nxt;
    logic        w_lock_hold, w_force_cpu, w_cpu_gnt, w_host_gnt, w_we, w_mmio;
    logic [31:0] w_addr, w_wdata, w_rdata;
    logic [7:0]  r_result;
    logic        r_result_valid, r_rd_cpu, r_rd_host, r_rd_mmio;
    logic [31:0] r_cpu_rdata, r_host_rdata;

    // A held lock overrides the pointer until the cap is hit while the CPU is waiting
    always_comb begin
        w_lock_hold    = (r_state == HOST_LOCKED) && host_req && host_lock;
        w_force_cpu    = w_lock_hold && cpu_req && (r_lock_cnt == LMAX);
        w_host_gnt     = w_lock_hold ? !w_force_cpu : host_req && (!cpu_req || r_ptr_host);
        w_cpu_gnt      = w_lock_hold ? w_force_cpu : cpu_req && (!host_req || !r_ptr_host);
        w_state_nxt    = w_cpu_gnt ? CPU_OWN : w_host_gnt ? (host_lock ? HOST_LOCKED : HOST_OWN) : IDLE;
        w_lock_cnt_nxt = !(w_host_gnt && host_lock) ? 8'd0 :
                         !w_lock_hold ? 8'd1 :
                         (r_lock_cnt == LMAX) ? LMAX : r_lock_cnt + 8'd1;
        w_ptr_nxt      = w_cpu_gnt ? 1'b1 : w_host_gnt ? 1'b0 : r_ptr_host;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr_host <= 1'b0;
            r_lock_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr_host <= w_ptr_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    assign w_we      = w_cpu_gnt ? cpu_we : w_host_gnt && host_we;
    assign w_addr    = w_cpu_gnt ? cpu_addr : w_host_gnt ? host_addr : '0;
    assign w_wdata   = w_cpu_gnt ? cpu_wdata : w_host_gnt ? host_wdata : '0;
    assign w_mmio    = (w_cpu_gnt || w_host_gnt) && (w_addr == MMIO_ADDR);
    assign w_rdata   = r_rd_mmio ? {24'b0, r_result} : mem_rdata;

    assign mem_we    = w_we && !w_mmio;
    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;
    assign host_gnt  = w_host_gnt;
    assign cpu_stall = cpu_req && !w_cpu_gnt;

    // Each master's rdata is live on its rvalid cycle and holds its last value otherwise
    assign cpu_rvalid   = r_rd_cpu;
    assign host_rvalid  = r_rd_host;
    assign cpu_rdata    = r_rd_cpu ? w_rdata : r_cpu_rdata;
    assign host_rdata   = r_rd_host ? w_rdata : r_host_rdata;
    assign result       = r_result;
    assign result_valid = r_result_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_result       <= 8'd0;
            r_result_valid <= 1'b0;
            r_rd_cpu       <= 1'b0;
            r_rd_host      <= 1'b0;
            r_rd_mmio      <= 1'b0;
            r_cpu_rdata    <= '0;
            r_host_rdata   <= '0;
        end else begin
            r_result_valid <= w_we && w_mmio;
            if (w_we && w_mmio)
                r_result <= w_wdata[7:0];
            r_rd_cpu  <= w_cpu_gnt && !cpu_we;
            r_rd_host <= w_host_gnt && !host_we;
            r_rd_mmio <= w_mmio;
            if (r_rd_cpu)
                r_cpu_rdata <= w_rdata;
            if (r_rd_host)
                r_host_rdata <= w_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus with queued expectations checked by a decoupled monitor
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        host_req = 1'b0, host_lock = 1'b0, host_we = 1'b0;
    logic [31:0] host_addr = '0, host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  result;
    logic        result_valid;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.MMIO_ADDR(32'h02000000), .LOCK_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_lock(host_lock), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .result(result), .result_valid(result_valid)
    );

    // Registered memory model: read data is the address with a fixed upper pattern
    always @(posedge clk) mem_rdata <= mem_addr ^ 32'hA5A50000;

    typedef struct {
        logic       hg;
        logic       st;
        logic       we;
        logic [7:0] res;
    } exp_t;

    exp_t        cyc_q[$];
    logic [31:0] cpu_q[$];
    logic [31:0] host_q[$];
    logic [7:0]  res_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst_n,
                        input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic hr, input logic hl, input logic hw, input logic [31:0] ha, input logic [31:0] hd,
                        input logic eh, input logic es, input logic ew, input logic [7:0] eres);
        @(posedge clk);
        #1;
        reset = rst_n;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_lock = hl; host_we = hw; host_addr = ha; host_wdata = hd;
        cyc_q.push_back('{eh, es, ew, eres});
    endtask

    task automatic idle(input logic [7:0] eres);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eres);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("host_gnt", 32'(host_gnt), 32'(e.hg));
            chk("cpu_stall", 32'(cpu_stall), 32'(e.st));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("result", 32'(result), 32'(e.res));
        end
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
            else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (host_rvalid) begin
            if (host_q.size() == 0) chk("host_rvalid_unexpected", 32'(host_rvalid), 32'd0);
            else chk("host_rdata", host_rdata, host_q.pop_front());
        end
        if (result_valid) begin
            if (res_q.size() == 0) chk("result_valid_unexpected", 32'(result_valid), 32'd0);
            else chk("result_pulse", 32'(result), 32'(res_q.pop_front()));
        end
    end

    initial begin
        @(posedge clk);
        // Reset held with both masters requesting reads: CPU shown granted, nothing returns
        step(0, 1, 0, 32'h100, 0, 1, 0, 0, 32'h200, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 32'h100, 0, 1, 0, 0, 32'h200, 0, 0, 0, 0, 8'h00);
        // Contention: C, H, C, H
        step(1, 1, 0, 32'h100, 0, 1, 0, 0, 32'h200, 0, 0, 0, 0, 8'h00); cpu_q.push_back(32'hA5A50100);
        step(1, 1, 0, 32'h104, 0, 1, 0, 0, 32'h204, 0, 1, 1, 0, 8'h00); host_q.push_back(32'hA5A50204);
        step(1, 1, 0, 32'h108, 0, 1, 0, 0, 32'h208, 0, 0, 0, 0, 8'h00); cpu_q.push_back(32'hA5A50108);
        step(1, 1, 0, 32'h10C, 0, 1, 0, 0, 32'h20C, 0, 1, 1, 0, 8'h00); host_q.push_back(32'hA5A5020C);
        // MMIO write by CPU, readback by host, then a plain CPU memory write
        step(1, 1, 1, 32'h02000000, 32'h123456A5, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00); res_q.push_back(8'hA5);
        step(1, 0, 0, 0, 0, 1, 0, 0, 32'h02000000, 0, 1, 0, 0, 8'hA5); host_q.push_back(32'h000000A5);
        step(1, 1, 1, 32'h300, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 1, 8'hA5);
        // Lock cap: 8 host grants, CPU on the 9th, host resumes
        for (int k = 0; k < 11; k++) begin
            if (k == 8) begin
                step(1, 1, 0, 32'h400, 0, 1, 1, 1, 32'h20000000 + 32'(4 * k), 32'(k), 0, 0, 0, 8'hA5);
                cpu_q.push_back(32'hA5A50400);
            end else begin
                step(1, 1, 0, 32'h400, 0, 1, 1, 1, 32'h20000000 + 32'(4 * k), 32'(k), 1, 1, 1, 8'hA5);
            end
        end
        idle(8'hA5);
        // Lock with no CPU demand never yields; count saturates so a later CPU request wins at once
        for (int k = 0; k < 20; k++)
            step(1, 0, 0, 0, 0, 1, 1, 1, 32'h20001000 + 32'(4 * k), 32'(k), 1, 0, 1, 8'hA5);
        step(1, 1, 0, 32'h500, 0, 1, 1, 1, 32'h20002000, 0, 0, 0, 0, 8'hA5); cpu_q.push_back(32'hA5A50500);
        idle(8'hA5);
        // Reset lands on the edge after a granted host read
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h600, 0, 1, 0, 0, 8'hA5);
        idle(8'h00);
        step(1, 1, 0, 32'h700, 0, 1, 0, 0, 32'h800, 0, 0, 0, 0, 8'h00); cpu_q.push_back(32'hA5A50700);
        idle(8'h00);
        idle(8'h00);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("host_q_drained", 32'(host_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
